// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiplier and restoring divider behind valid/ready.
// Define MULDIV_DIV_EN to build the divider; without it, divide requests complete as illegal.
module muldiv_unit #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = $clog2(XLEN + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [9:0]      Funct_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            kill_i,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o,
    output logic            illegal_o
);

    localparam int unsigned      ACC_W    = 2 * XLEN;
    localparam logic [6:0]       FUNCT7_M = 7'b0000001;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
`ifdef MULDIV_DIV_EN
    localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
`ifdef MULDIV_DIV_EN
        S_DIV  = 2'd2,
`endif
        S_DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic [1:0]        f3_q, f3_d;
    logic              neg_q, neg_d;
    logic              valid_q, valid_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              illegal_q, illegal_d;

    logic [6:0]        funct7;
    logic [2:0]        funct3;
    logic              accept;
    logic              sign_a, sign_b;
    logic              a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              acc_neg;

    logic [XLEN:0]     mul_sum;
    logic [ACC_W-1:0]  mul_nxt;
    logic [ACC_W-1:0]  mul_prod;
    logic [XLEN-1:0]   mul_res;

    assign funct7  = Funct_i[9:3];
    assign funct3  = Funct_i[2:0];
    assign ready_o = (state_q == S_IDLE) || (state_q == S_DONE);
    assign accept  = valid_i && ready_o && !kill_i;

    // Operand signedness: mulh/mulhsu sign rs1, mulh signs rs2; div/rem sign both.
    assign sign_a  = funct3[2] ? !funct3[0] : (funct3[1:0] == 2'b01) || (funct3[1:0] == 2'b10);
    assign sign_b  = funct3[2] ? !funct3[0] : (funct3[1:0] == 2'b01);
    assign a_neg   = sign_a && rs1_i[XLEN-1];
    assign b_neg   = sign_b && rs2_i[XLEN-1];
    assign a_mag   = a_neg ? -rs1_i : rs1_i;
    assign b_mag   = b_neg ? -rs2_i : rs2_i;
    // Remainder follows the dividend; everything else follows the product/quotient sign.
    assign acc_neg = (funct3[2] && funct3[1]) ? a_neg : (a_neg ^ b_neg);

    // Shift-add step: multiplier sits in the low half and shifts out as the product shifts in.
    assign mul_sum  = {1'b0, acc_q[ACC_W-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : {(XLEN+1){1'b0}});
    assign mul_nxt  = {mul_sum, acc_q[XLEN-1:1]};
    assign mul_prod = neg_q ? -mul_nxt : mul_nxt;
    assign mul_res  = (f3_q == 2'b00) ? mul_prod[XLEN-1:0] : mul_prod[ACC_W-1:XLEN];

`ifdef MULDIV_DIV_EN
    logic              div_by_zero, div_ovf;
    logic [XLEN:0]     div_rs, div_diff;
    logic              div_ge;
    logic [ACC_W-1:0]  div_nxt;
    logic [XLEN-1:0]   div_sel, div_res;

    assign div_by_zero = (rs2_i == '0);
    assign div_ovf     = !funct3[0] && (rs1_i == MIN_NEG) && (rs2_i == '1);

    // Restoring step: partial remainder in the high half, dividend/quotient in the low half.
    assign div_rs   = acc_q[ACC_W-1:XLEN-1];
    assign div_diff = div_rs - {1'b0, opb_q};
    assign div_ge   = !div_diff[XLEN];
    assign div_nxt  = {(div_ge ? div_diff[XLEN-1:0] : div_rs[XLEN-1:0]), acc_q[XLEN-2:0], div_ge};
    assign div_sel  = f3_q[1] ? div_nxt[ACC_W-1:XLEN] : div_nxt[XLEN-1:0];
    assign div_res  = neg_q ? -div_sel : div_sel;
`endif

    // Next-state and datapath update.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opb_d     = opb_q;
        f3_d      = f3_q;
        neg_d     = neg_q;
        valid_d   = 1'b0;
        result_d  = result_q;
        illegal_d = illegal_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (accept) begin
                    cnt_d = '0;
                    f3_d  = funct3[1:0];
                    neg_d = acc_neg;
                    if (funct7 != FUNCT7_M) begin
                        state_d   = S_DONE;
                        valid_d   = 1'b1;
                        result_d  = '0;
                        illegal_d = 1'b1;
                    end else if (!funct3[2]) begin
                        state_d = S_MUL;
                        acc_d   = {{XLEN{1'b0}}, b_mag};
                        opb_d   = a_mag;
                    end else begin
`ifdef MULDIV_DIV_EN
                        if (div_by_zero) begin
                            state_d   = S_DONE;
                            valid_d   = 1'b1;
                            result_d  = funct3[1] ? rs1_i : '1;
                            illegal_d = 1'b0;
                        end else if (div_ovf) begin
                            state_d   = S_DONE;
                            valid_d   = 1'b1;
                            result_d  = funct3[1] ? '0 : MIN_NEG;
                            illegal_d = 1'b0;
                        end else begin
                            state_d = S_DIV;
                            acc_d   = {{XLEN{1'b0}}, a_mag};
                            opb_d   = b_mag;
                        end
`else
                        state_d   = S_DONE;
                        valid_d   = 1'b1;
                        result_d  = '0;
                        illegal_d = 1'b1;
`endif
                    end
                end
            end
            S_MUL: begin
                acc_d = mul_nxt;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d   = S_DONE;
                    valid_d   = 1'b1;
                    result_d  = mul_res;
                    illegal_d = 1'b0;
                end
            end
`ifdef MULDIV_DIV_EN
            S_DIV: begin
                acc_d = div_nxt;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d   = S_DONE;
                    valid_d   = 1'b1;
                    result_d  = div_res;
                    illegal_d = 1'b0;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        // A flush drops the in-flight operation without publishing anything.
        if (kill_i) begin
            state_d   = S_IDLE;
            valid_d   = 1'b0;
            result_d  = result_q;
            illegal_d = illegal_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opb_q     <= '0;
            f3_q      <= '0;
            neg_q     <= 1'b0;
            valid_q   <= 1'b0;
            result_q  <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opb_q     <= opb_d;
            f3_q      <= f3_d;
            neg_q     <= neg_d;
            valid_q   <= valid_d;
            result_q  <= result_d;
            illegal_q <= illegal_d;
        end
    end

    assign valid_o   = valid_q;
    assign result_o  = result_q;
    assign illegal_o = illegal_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (XLEN=32); divide expectations follow MULDIV_DIV_EN.
module tb_muldiv_unit;

    localparam logic [9:0] F_MUL    = {7'b0000001, 3'd0};
    localparam logic [9:0] F_MULH   = {7'b0000001, 3'd1};
    localparam logic [9:0] F_MULHSU = {7'b0000001, 3'd2};
    localparam logic [9:0] F_MULHU  = {7'b0000001, 3'd3};
    localparam logic [9:0] F_DIV    = {7'b0000001, 3'd4};
    localparam logic [9:0] F_DIVU   = {7'b0000001, 3'd5};
    localparam logic [9:0] F_REM    = {7'b0000001, 3'd6};
    localparam logic [9:0] F_REMU   = {7'b0000001, 3'd7};

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic        ready_o;
    logic [9:0]  Funct_i;
    logic [31:0] rs1_i;
    logic [31:0] rs2_i;
    logic        kill_i;
    logic        valid_o;
    logic [31:0] result_o;
    logic        illegal_o;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    muldiv_unit #(.XLEN(32)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .Funct_i   (Funct_i),
        .rs1_i     (rs1_i),
        .rs2_i     (rs2_i),
        .kill_i    (kill_i),
        .valid_o   (valid_o),
        .result_o  (result_o),
        .illegal_o (illegal_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one request for a single cycle; returns just after the accepting edge.
    task automatic issue(input logic [9:0] f, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk_i);
        valid_i = 1'b1;
        Funct_i = f;
        rs1_i   = a;
        rs2_i   = b;
        @(posedge clk_i);
        #1 valid_i = 1'b0;
    endtask

    // Cycles from acceptance until valid_o is seen (sampled on falling edges), bounded.
    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk_i);
            cyc++;
        end while (!valid_o && cyc < 100);
    endtask

    task automatic run(input string tag, input logic [9:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res,
                       input int exp_cyc, input logic exp_ill);
        int cyc;
        issue(f, a, b);
        wait_done(cyc);
        chk({tag, ".cyc"}, 32'(cyc), 32'(exp_cyc));
        chk({tag, ".res"}, result_o, exp_res);
        chk({tag, ".ill"}, 32'(illegal_o), 32'(exp_ill));
    endtask

    initial begin
        int  cyc;
        bit  saw;
        rst_i   = 1'b1;
        valid_i = 1'b0;
        kill_i  = 1'b0;
        Funct_i = '0;
        rs1_i   = '0;
        rs2_i   = '0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst.ready", 32'(ready_o), 32'd1);
        chk("rst.valid", 32'(valid_o), 32'd0);
        chk("rst.result", result_o, 32'd0);
        chk("rst.illegal", 32'(illegal_o), 32'd0);
        rst_i = 1'b0;

        run("mul", F_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 1'b0);
        @(negedge clk_i);
        chk("mul.pulse", 32'(valid_o), 32'd0);
        run("mulhu", F_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 1'b0);
        run("mulh", F_MULH, 32'h8000_0000, 32'd2, 32'hFFFF_FFFF, 33, 1'b0);
        run("mulhsu", F_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 1'b0);

`ifdef MULDIV_DIV_EN
        run("div", F_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 1'b0);
        run("rem", F_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 1'b0);
        run("remu", F_REMU, 32'd100, 32'd7, 32'd2, 33, 1'b0);
        run("divu0", F_DIVU, 32'd55, 32'd0, 32'hFFFF_FFFF, 1, 1'b0);
        run("divovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b0);
        run("rem0", F_REM, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 1, 1'b0);
        run("removf", F_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 1'b0);
`else
        run("div", F_DIV, 32'hFFFF_FFF9, 32'd2, 32'd0, 1, 1'b1);
        run("divu0", F_DIVU, 32'd55, 32'd0, 32'd0, 1, 1'b1);
        run("remu", F_REMU, 32'd100, 32'd7, 32'd0, 1, 1'b1);
`endif

        // Back-to-back: second request presented during the DONE cycle of the first.
        issue(F_MUL, 32'd6, 32'd7);
        wait_done(cyc);
        chk("b2b1.cyc", 32'(cyc), 32'd33);
        chk("b2b1.res", result_o, 32'd42);
        valid_i = 1'b1;
        Funct_i = F_DIVU;
        rs1_i   = 32'd100;
        rs2_i   = 32'd7;
        chk("b2b.ready_in_done", 32'(ready_o), 32'd1);
        @(posedge clk_i);
        #1 valid_i = 1'b0;
`ifdef MULDIV_DIV_EN
        chk("b2b2.busy", 32'(ready_o), 32'd0);
        wait_done(cyc);
        chk("b2b2.cyc", 32'(cyc), 32'd33);
        chk("b2b2.res", result_o, 32'd14);
        chk("b2b2.ill", 32'(illegal_o), 32'd0);
`else
        wait_done(cyc);
        chk("b2b2.cyc", 32'(cyc), 32'd1);
        chk("b2b2.res", result_o, 32'd0);
        chk("b2b2.ill", 32'(illegal_o), 32'd1);
`endif

        run("mul25", F_MUL, 32'd5, 32'd5, 32'd25, 33, 1'b0);
        run("illegal", 10'b0000000_000, 32'd5, 32'd5, 32'd0, 1, 1'b1);
        run("mul12", F_MUL, 32'd3, 32'd4, 32'd12, 33, 1'b0);

        // Kill at iteration 10: nothing published, result held.
        issue(F_MUL, 32'd9, 32'd9);
        repeat (10) @(negedge clk_i);
        kill_i = 1'b1;
        @(posedge clk_i);
        #1 kill_i = 1'b0;
        chk("kill.ready", 32'(ready_o), 32'd1);
        saw = 1'b0;
        repeat (40) begin
            @(negedge clk_i);
            if (valid_o) saw = 1'b1;
        end
        chk("kill.no_valid", 32'(saw), 32'd0);
        chk("kill.result", result_o, 32'd12);

        // Reset at iteration 10: all outputs to reset values.
        issue(F_MUL, 32'd9, 32'd9);
        repeat (10) @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        chk("rstop.ready", 32'(ready_o), 32'd1);
        chk("rstop.valid", 32'(valid_o), 32'd0);
        chk("rstop.result", result_o, 32'd0);
        chk("rstop.illegal", 32'(illegal_o), 32'd0);
        saw = 1'b0;
        repeat (40) begin
            @(negedge clk_i);
            if (valid_o) saw = 1'b1;
        end
        chk("rstop.no_valid", 32'(saw), 32'd0);

        run("recover", F_MUL, 32'd2, 32'd3, 32'd6, 33, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide execution unit for the RV32M operations (`mul`, `mulh`, `mulhsu`, `mulhu`, `div`, `divu`, `rem`, `remu`). It sits in the execute stage beside the single-cycle ALU and decodes the same 10-bit `{funct7, funct3}` field. It replaces the single-cycle `mul` path with a parametrised, multi-cycle shift-add multiplier and restoring divider behind a valid/ready handshake, so the pipeline stalls on `ready_o` while the unit is busy.

## Interface
- `XLEN`, default 32: operand and result width; must be ≥ 4.
- `CNT_W`, default `$clog2(XLEN+1)`: width of the iteration counter.

Clock and reset: one clock; reset is synchronous and active-high.
- `clk_i` in 1: clock; all state changes on the rising edge.
- `rst_i` in 1: synchronous, active-high reset.
- `valid_i` in 1: request present this cycle.
- `ready_o` out 1: unit can accept a request this cycle.
- `Funct_i` in 10: `{funct7, funct3}` of the instruction.
- `rs1_i` in XLEN: dividend or multiplicand.
- `rs2_i` in XLEN: divisor or multiplier.
- `kill_i` in 1: abort the in-flight operation (pipeline flush).
- `valid_o` out 1: one-cycle pulse; `result_o` and `illegal_o` are valid.
- `result_o` out XLEN: result; held until the next completion.
- `illegal_o` out 1: the completed request had a non-M `funct7`.

## Operation
- **Accept.** A request is accepted when `valid_i && ready_o && !kill_i`. Operands and `funct3` are latched on acceptance.
- **States:**
  - IDLE: `ready_o`=1.
  - MUL: `ready_o`=0.
  - DIV: `ready_o`=0.
  - DONE: `valid_o`=1 and `ready_o`=1.
- **Transitions:**
  - IDLE or DONE, on accept: `funct7`≠`0000001` → DONE with `illegal_o`=1 and `result_o`=0.
  - IDLE or DONE, on accept: `funct3[2]`=0 → MUL.
  - IDLE or DONE, on accept: `funct3[2]`=1 → DIV, or DONE if it is a division special case.
  - MUL or DIV: stay until the counter reaches XLEN, then go to DONE.
  - DONE with no accept → IDLE.
- **Signedness:**
  - Signed operands are converted to magnitudes on acceptance and the sign is applied at completion.
  - `mulh`: both operands signed. `mulhsu`: `rs1` signed, `rs2` unsigned. `mulhu`, `divu`, `remu`: both unsigned.
  - `div` and `rem`: both signed. The remainder takes the sign of the dividend.
- **Multiply:**
  - One shift-add step per cycle into a 2·XLEN accumulator.
  - `mul` returns `[XLEN-1:0]`; the `mulh*` variants return `[2·XLEN-1:XLEN]`.
- **Divide:** restoring division, one quotient bit per cycle.
- **Division special cases** (resolved on acceptance, no iteration):
  - Divide by zero: quotient = all ones, remainder = `rs1`.
  - Signed overflow (`rs1` = most-negative value, `rs2` = −1): quotient = most-negative value, remainder = 0.
- **Kill:**
  - `kill_i` in MUL, DIV or DONE returns the FSM to IDLE on the next edge.
  - No `valid_o` is produced for the killed operation, and `result_o` keeps its previous value.
  - `kill_i` together with `valid_i` means the request is not accepted.
- **Reset:**
  - `rst_i` overrides everything, including mid-operation; the FSM goes to IDLE.
  - Reset values: `ready_o`=1, `valid_o`=0, `result_o`=0, `illegal_o`=0, counter=0.

## Timing
- **Accept and completion timing** (accept on the edge ending cycle N):
  - Iterating ops: MUL or DIV during cycles N+1 … N+XLEN; `valid_o`=1 in cycle N+XLEN+1.
  - Special-case divisions and illegal requests: `valid_o`=1 in cycle N+1.
- **Back-to-back:** a request accepted in a DONE cycle starts the next operation immediately, with no idle bubble.
- **Outputs:** `result_o` and `illegal_o` are registered and update only in the cycle `valid_o` rises.
- **No backpressure:** `valid_o` is a single-cycle pulse; the consumer must capture it.
- **Combinational input-to-output paths:** none, except `ready_o`, which is a pure function of state.

## Configuration
- Macro: `MULDIV_DIV_EN`.
- **Defined:** full behaviour as specified.
- **Undefined:**
  - The divider datapath and the DIV state are compiled out.
  - Requests with `funct3[2]`=1 complete in DONE at cycle N+1 with `illegal_o`=1 and `result_o`=0.
  - The multiply path is unchanged.

## Test plan
All scenarios use `XLEN`=32.
- `mul`, `rs1`=7, `rs2`=−3 → `result_o`=0xFFFFFFEB; `valid_o` exactly 33 cycles after acceptance.
- `mulhu`, `rs1`=`rs2`=0xFFFFFFFF → 0xFFFFFFFE. `mulh`, `rs1`=0x80000000, `rs2`=2 → 0xFFFFFFFF.
- `div` and `rem`, `rs1`=−7, `rs2`=2 → −3 (0xFFFFFFFD) and −1. `divu`, `rs2`=0 → 0xFFFFFFFF with `valid_o` 1 cycle after acceptance. `div`, 0x80000000 / −1 → 0x80000000.
- Back-to-back: `mul` then `divu` 100/7, with the second `valid_i` asserted during DONE → second accepted immediately; results 0x…, then 14, with no idle cycle between operations.
- `kill_i` at iteration 10 of a `mul` → no `valid_o`; `result_o` unchanged; `ready_o`=1 next cycle. Repeat the scenario with `rst_i` → all outputs at reset values.
- `Funct_i`={0000000, 000} with `valid_i` → `illegal_o`=1, `result_o`=0 next cycle. With `MULDIV_DIV_EN` undefined, `divu` → `illegal_o`=1.
